transport_tx: RTL and testbench
===============================

Name: transport_tx

Overview:
- Transmit half of the transport layer; the consumer side of the session block's `cmd`/`dataOut`/`transportBusy` interface.
- Accepts control words and audio samples from the session layer and buffers audio in a small FIFO.
- Frames words into byte-serial packets with sync byte, header, length and checksum.
- Drives them to the link layer over a valid/ready byte handshake.

Parameters:
- AUDIO_WORDS, 4: audio samples per audio packet (1..FIFO_DEPTH).
- FIFO_DEPTH, 8: audio FIFO depth in 16-bit words (power of 2).
- SYNC_BYTE, 8'hA5: first byte of every packet.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- cmd  input  2  word type from session: 00 none, 01 control, 10 audio, 11 reserved.
- dataIn  input  16  word from session; sampled together with cmd.
- transportBusy  output  1  backpressure to session; word not accepted while high.
- txByte  output  8  packet byte to link layer.
- txValid  output  1  txByte holds a valid byte.
- txReady  input  1  link layer accepts txByte this cycle.
- pktDone  output  1  one-cycle pulse when the last byte of a packet is accepted.
- dropCount  output  8  words offered while busy; saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - txValid=0, txByte=0, pktDone=0, dropCount=0, transportBusy=0.
  - FIFO emptied, control holding register cleared, sequence number=0, FSM=IDLE.
  - A reset mid-packet abandons that packet; no trailing bytes are emitted after release.
- Acceptance:
  - transportBusy = (FIFO count == FIFO_DEPTH) OR ctrlValid. It is derived from registered state only.
  - A word is accepted on a rising edge when cmd is 01 or 10 and transportBusy==0.
  - cmd=01 loads the control holding register (1 deep) and sets ctrlValid.
  - cmd=10 pushes dataIn into the FIFO.
  - cmd=01/10 while transportBusy=1: word dropped; dropCount increments, saturating at 255.
  - cmd=11: ignored and not counted.
- Packet format, bytes in order:
  - SYNC_BYTE.
  - Header = {type[1:0], seq[5:0]}; type 01 = control, 10 = audio.
  - Length in 16-bit words: 1 for control, AUDIO_WORDS for audio.
  - Payload words, each MSB byte then LSB byte.
  - Checksum = 8-bit sum mod 256 of header, length and all payload bytes; SYNC_BYTE is excluded.
- FSM states: IDLE, SYNC, HDR, LEN, PAY_HI, PAY_LO, CSUM.
  - IDLE: if ctrlValid, start a control packet. Else if FIFO count >= AUDIO_WORDS, start an audio packet. Else stay.
  - Control has priority, evaluated only in IDLE; a packet in progress is never interrupted.
  - Starting a packet latches type and seq. The next cycle presents SYNC with txValid=1.
  - Each state advances only on txValid && txReady.
  - txByte and txValid are held stable while txReady=0.
  - PAY_HI -> PAY_LO, then PAY_LO -> PAY_HI if payload words remain, else -> CSUM.
  - Control payload word is read from the holding register. ctrlValid clears when the control LSB byte is accepted.
  - Audio words pop from the FIFO head when the LSB byte is accepted.
  - CSUM accepted -> pktDone=1 for one cycle, seq increments (63 wraps to 0), FSM -> IDLE.
  - txValid=0 in IDLE; at least one idle cycle separates packets.
- Simultaneous events:
  - A push and a pop in the same cycle are both performed.
  - A FIFO full at the start of a cycle stays busy that cycle even if a pop occurs.
  - A control word arriving during an audio packet waits in the holding register until IDLE.
- Checksum is accumulated incrementally as bytes are accepted, not recomputed from the FIFO.

Test Plan:
- Reset released, cmd=01 dataIn=16'h0001 for one cycle, txReady=1:
  - Bytes A5, 40, 01, 00, 01, 42 are emitted.
  - pktDone pulses on the 42 byte; transportBusy is high from the accept cycle until the 01 payload LSB is accepted.
- Four audio writes 1234, 5678, 9ABC, DEF0 after the previous packet (seq=1):
  - Bytes A5, 81, 04, 12, 34, 56, 78, 9A, BC, DE, F0, BD are emitted.
- txReady held 0 for 5 cycles mid-payload:
  - txByte/txValid are unchanged throughout.
  - Sequence resumes exactly on release, with no duplicated or skipped byte.
- With txReady=0, write 8 audio words, then 3 more:
  - transportBusy=1 after the 8th word.
  - dropCount=3; FIFO contents intact.
- Audio packet in progress, then a control word 0005 arrives:
  - The audio packet completes unaltered.
  - The next packet is the control packet (header type 01).
- Assert reset mid-payload:
  - txValid drops immediately (asynchronous).
  - After release: no output until new words arrive; the first packet has seq=0.

Source files
------------

// File: rtl/transport_tx.sv
// ---------------------------------------------------------------------------
// transport_tx
//
// Transmit half of the transport layer. Takes control words and audio samples
// from the session layer, holds one control word and a small audio FIFO, and
// frames them into byte-serial packets for the link layer:
//
//     SYNC_BYTE, {type[1:0], seq[5:0]}, length, payload (MSB, LSB)..., checksum
//
// The checksum is the 8-bit sum of header, length and payload bytes.
//
// Ports:
//     clk            system clock, rising edge
//     reset          asynchronous reset, active low
//     cmd[1:0]       word type from session: 00 none, 01 control, 10 audio
//     dataIn[15:0]   word from session, sampled together with cmd
//     transportBusy  high while a new word cannot be accepted
//     txByte[7:0]    packet byte to the link layer
//     txValid        txByte holds a valid byte
//     txReady        link layer accepts txByte this cycle
//     pktDone        one-cycle pulse when the checksum byte is accepted
//     dropCount[7:0] saturating count of words offered while busy
// ---------------------------------------------------------------------------
module transport_tx #(
    parameter int         AUDIO_WORDS = 4,
    parameter int         FIFO_DEPTH  = 8,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  cmd,
    input  logic [15:0] dataIn,
    output logic        transportBusy,
    output logic [7:0]  txByte,
    output logic        txValid,
    input  logic        txReady,
    output logic        pktDone,
    output logic [7:0]  dropCount
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] PKT_CNT   = CW'(AUDIO_WORDS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [7:0]    AUDIO_LEN = 8'(AUDIO_WORDS);

    localparam logic [1:0] CMD_CTRL  = 2'b01;
    localparam logic [1:0] CMD_AUDIO = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        HDR,
        LEN,
        PAY_HI,
        PAY_LO,
        CSUM
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  pkt_type_q, pkt_type_d;
    logic [5:0]  seq_q, seq_d;
    logic [7:0]  words_left_q, words_left_d;
    logic [7:0]  csum_q, csum_d;
    logic        ctrl_valid_q, ctrl_valid_d;
    logic [15:0] ctrl_word_q, ctrl_word_d;
    logic [7:0]  drop_q, drop_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0] fifo_mem_q [FIFO_DEPTH];

    logic        busy;
    logic        accept;
    logic        push;
    logic        pop;
    logic        ctrl_load;
    logic        ctrl_clear;
    logic        offered;
    logic        pkt_done;
    logic        is_ctrl_pkt;
    logic [15:0] pay_word;
    logic [7:0]  tx_byte;

    // Busy comes only from registered state, so a full FIFO stays busy for
    // the whole cycle even if a pop happens on the closing edge.
    always_comb begin
        busy        = (count_q == FULL_CNT) || ctrl_valid_q;
        offered     = (cmd == CMD_CTRL) || (cmd == CMD_AUDIO);
        push        = (cmd == CMD_AUDIO) && !busy;
        ctrl_load   = (cmd == CMD_CTRL) && !busy;
        is_ctrl_pkt = (pkt_type_q == CMD_CTRL);
        pay_word    = is_ctrl_pkt ? ctrl_word_q : fifo_mem_q[rd_ptr_q];
        accept      = (state_q != IDLE) && txReady;
    end

    // The outgoing byte is a pure function of registered state, so it stays
    // put while the link layer stalls and vanishes as soon as reset hits.
    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            SYNC:    tx_byte = SYNC_BYTE;
            HDR:     tx_byte = {pkt_type_q, seq_q};
            LEN:     tx_byte = is_ctrl_pkt ? 8'd1 : AUDIO_LEN;
            PAY_HI:  tx_byte = pay_word[15:8];
            PAY_LO:  tx_byte = pay_word[7:0];
            CSUM:    tx_byte = csum_q;
            default: tx_byte = 8'h00;
        endcase
    end

    // Packet sequencing. A packet is chosen only from IDLE with control
    // first; once started it runs to the checksum. The checksum is built up
    // byte by byte as each header, length and payload byte is accepted.
    always_comb begin
        state_d      = state_q;
        pkt_type_d   = pkt_type_q;
        seq_d        = seq_q;
        words_left_d = words_left_q;
        csum_d       = csum_q;
        pop          = 1'b0;
        ctrl_clear   = 1'b0;
        pkt_done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ctrl_valid_q) begin
                    pkt_type_d   = CMD_CTRL;
                    words_left_d = 8'd1;
                    csum_d       = 8'h00;
                    state_d      = SYNC;
                end else if (count_q >= PKT_CNT) begin
                    pkt_type_d   = CMD_AUDIO;
                    words_left_d = AUDIO_LEN;
                    csum_d       = 8'h00;
                    state_d      = SYNC;
                end
            end
            SYNC: begin
                if (accept) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    csum_d  = csum_q + tx_byte;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    csum_d  = csum_q + tx_byte;
                    state_d = PAY_HI;
                end
            end
            PAY_HI: begin
                if (accept) begin
                    csum_d  = csum_q + tx_byte;
                    state_d = PAY_LO;
                end
            end
            PAY_LO: begin
                if (accept) begin
                    csum_d = csum_q + tx_byte;
                    if (is_ctrl_pkt) begin
                        ctrl_clear = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                    if (words_left_q == 8'd1) begin
                        state_d = CSUM;
                    end else begin
                        words_left_d = words_left_q - 8'd1;
                        state_d      = PAY_HI;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    pkt_done = 1'b1;
                    seq_d    = seq_q + 6'd1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Input side: FIFO pointers/occupancy, the one-deep control holder and
    // the saturating drop counter. A control clear and a control load can
    // never coincide because the holder keeps the block busy until cleared.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        ctrl_valid_d = ctrl_valid_q;
        ctrl_word_d  = ctrl_word_q;
        drop_d       = drop_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (ctrl_clear) begin
            ctrl_valid_d = 1'b0;
        end
        if (ctrl_load) begin
            ctrl_valid_d = 1'b1;
            ctrl_word_d  = dataIn;
        end

        if (offered && busy && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // State registers. Reset abandons any packet in flight and empties the
    // FIFO, so nothing is emitted after release until new words arrive.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pkt_type_q   <= 2'b00;
            seq_q        <= 6'd0;
            words_left_q <= 8'd0;
            csum_q       <= 8'h00;
            ctrl_valid_q <= 1'b0;
            ctrl_word_q  <= 16'h0000;
            drop_q       <= 8'd0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pkt_type_q   <= pkt_type_d;
            seq_q        <= seq_d;
            words_left_q <= words_left_d;
            csum_q       <= csum_d;
            ctrl_valid_q <= ctrl_valid_d;
            ctrl_word_q  <= ctrl_word_d;
            drop_q       <= drop_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // FIFO storage; written only when a push is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= 16'h0000;
            end
        end else if (push) begin
            fifo_mem_q[wr_ptr_q] <= dataIn;
        end
    end

    assign transportBusy = busy;
    assign txByte        = tx_byte;
    assign txValid       = (state_q != IDLE);
    assign pktDone       = pkt_done;
    assign dropCount     = drop_q;

endmodule

// File: tb/tb_transport_tx.sv
// ---------------------------------------------------------------------------
// tb_transport_tx
//
// Bench for transport_tx. A transaction-level model keeps the words the
// session layer has handed over (audio queue, control holder, sequence,
// drop count) and, whenever a packet must start, builds the whole expected
// byte stream for it. A negedge monitor compares every accepted link byte,
// pktDone, busy and dropCount against that model; scenario tasks add their
// own fixed-value checks.
// ---------------------------------------------------------------------------
module tb_transport_tx;

    localparam int         AUDIO_WORDS = 4;
    localparam int         FIFO_DEPTH  = 8;
    localparam logic [7:0] SYNC_BYTE   = 8'hA5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic [15:0] dataIn = 16'h0000;
    logic        txReady = 1'b0;
    logic        transportBusy;
    logic [7:0]  txByte;
    logic        txValid;
    logic        pktDone;
    logic [7:0]  dropCount;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_fifo [$];
    bit          m_ctrl_valid = 0;
    logic [15:0] m_ctrl_word = 16'h0000;
    int          m_seq = 0;
    int          m_drop = 0;

    bit          in_flight = 0;
    bit          exp_is_ctrl = 0;
    logic [7:0]  exp_bytes [$];
    int          exp_idx = 0;

    bit          snap_idle = 1;
    bit          snap_ctrl = 0;
    int          snap_cnt = 0;

    bit          prev_stall = 0;
    logic [7:0]  prev_byte = 8'h00;

    logic [7:0]  obs_log [$];
    logic [7:0]  hdr_log [$];
    int          pkt_count = 0;

    transport_tx #(
        .AUDIO_WORDS(AUDIO_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SYNC_BYTE  (SYNC_BYTE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd          (cmd),
        .dataIn       (dataIn),
        .transportBusy(transportBusy),
        .txByte       (txByte),
        .txValid      (txValid),
        .txReady      (txReady),
        .pktDone      (pktDone),
        .dropCount    (dropCount)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Negedge monitor and reference model. At each negedge the outputs
    // reflect the last rising edge, and cmd/dataIn/txReady hold the values
    // the next rising edge will sample.
    always @(negedge clk) begin : monitor
        bit         expect_start;
        bit         was_flight;
        bit         model_busy;
        bit         do_pop;
        bit         do_clear;
        bit         last;
        int         sum;
        logic [7:0] hdr;
        if (!reset) begin
            m_fifo.delete();
            m_ctrl_valid = 0;
            m_seq        = 0;
            m_drop       = 0;
            in_flight    = 0;
            exp_bytes.delete();
            exp_idx      = 0;
            snap_idle    = 1;
            snap_ctrl    = 0;
            snap_cnt     = 0;
            prev_stall   = 0;
        end else begin
            do_pop   = 0;
            do_clear = 0;

            // Packet start: the decision was made from the state of the
            // previous cycle, captured in the snapshot.
            if (!in_flight) begin
                expect_start = snap_idle && (snap_ctrl || snap_cnt >= AUDIO_WORDS);
                checks++;
                if (txValid !== expect_start) begin
                    errors++;
                    $display("[TB] FAIL pkt_start: txValid=%0b required=%0b", txValid, expect_start);
                end
                if (txValid && expect_start) begin
                    exp_bytes.delete();
                    exp_idx = 0;
                    exp_bytes.push_back(SYNC_BYTE);
                    if (snap_ctrl) begin
                        exp_is_ctrl = 1;
                        hdr = {2'b01, 6'(m_seq)};
                        exp_bytes.push_back(hdr);
                        exp_bytes.push_back(8'd1);
                        exp_bytes.push_back(m_ctrl_word[15:8]);
                        exp_bytes.push_back(m_ctrl_word[7:0]);
                    end else begin
                        exp_is_ctrl = 0;
                        hdr = {2'b10, 6'(m_seq)};
                        exp_bytes.push_back(hdr);
                        exp_bytes.push_back(8'(AUDIO_WORDS));
                        for (int i = 0; i < AUDIO_WORDS; i++) begin
                            exp_bytes.push_back(m_fifo[i][15:8]);
                            exp_bytes.push_back(m_fifo[i][7:0]);
                        end
                    end
                    sum = 0;
                    for (int i = 1; i < exp_bytes.size(); i++) begin
                        sum += int'(exp_bytes[i]);
                    end
                    exp_bytes.push_back(8'(sum));
                    in_flight = 1;
                end
            end
            was_flight = in_flight;

            model_busy = (m_fifo.size() == FIFO_DEPTH) || m_ctrl_valid;
            checks++;
            if (transportBusy !== model_busy) begin
                errors++;
                $display("[TB] FAIL busy: transportBusy=%0b required=%0b", transportBusy, model_busy);
            end
            checks++;
            if (dropCount !== 8'(m_drop)) begin
                errors++;
                $display("[TB] FAIL drop_count: dropCount=%0d required=%0d", dropCount, m_drop);
            end

            if (prev_stall) begin
                checks++;
                if (txValid !== 1'b1 || txByte !== prev_byte) begin
                    errors++;
                    $display("[TB] FAIL hold: txValid=%0b txByte=%02h required valid=1 byte=%02h",
                             txValid, txByte, prev_byte);
                end
            end

            if (txValid && txReady) begin
                obs_log.push_back(txByte);
            end

            if (txValid && txReady && in_flight) begin
                last = (exp_idx == exp_bytes.size() - 1);
                checks++;
                if (txByte !== exp_bytes[exp_idx]) begin
                    errors++;
                    $display("[TB] FAIL byte[%0d]: txByte=%02h required=%02h",
                             exp_idx, txByte, exp_bytes[exp_idx]);
                end
                checks++;
                if (pktDone !== last) begin
                    errors++;
                    $display("[TB] FAIL pkt_done: pktDone=%0b required=%0b", pktDone, last);
                end
                if (exp_idx == 1) begin
                    hdr_log.push_back(txByte);
                end
                if (exp_idx >= 3 && !last && ((exp_idx - 3) % 2 == 1)) begin
                    if (exp_is_ctrl) do_clear = 1;
                    else             do_pop = 1;
                end
                if (last) begin
                    m_seq     = (m_seq + 1) % 64;
                    in_flight = 0;
                    pkt_count++;
                end
                exp_idx++;
            end else begin
                checks++;
                if (pktDone !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL pkt_done_idle: pktDone=%0b required=0", pktDone);
                end
            end

            prev_stall = txValid && !txReady;
            prev_byte  = txByte;

            snap_idle = !was_flight;
            snap_ctrl = m_ctrl_valid;
            snap_cnt  = m_fifo.size();

            // Word offered to the upcoming edge
            if (cmd == 2'b01 || cmd == 2'b10) begin
                if (model_busy) begin
                    if (m_drop < 255) m_drop++;
                end else if (cmd == 2'b01) begin
                    m_ctrl_valid = 1;
                    m_ctrl_word  = dataIn;
                end else begin
                    m_fifo.push_back(dataIn);
                end
            end
            if (do_pop)   void'(m_fifo.pop_front());
            if (do_clear) m_ctrl_valid = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [1:0] c, input logic [15:0] d);
        cmd    = c;
        dataIn = d;
        tick();
        cmd    = 2'b00;
    endtask

    task automatic drain(input int budget, output bit ok);
        int quiet;
        quiet = 0;
        ok    = 0;
        cmd   = 2'b00;
        txReady = 1'b1;
        for (int n = 0; n < budget && !ok; n++) begin
            tick();
            if (!in_flight && !m_ctrl_valid && m_fifo.size() < AUDIO_WORDS && !txValid)
                quiet++;
            else
                quiet = 0;
            if (quiet >= 3) ok = 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (txValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %0b required 0", txValid); end
        checks++;
        if (txByte !== 8'h00) begin errors++; $display("[TB] FAIL rst_byte: got %02h required 00", txByte); end
        checks++;
        if (pktDone !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %0b required 0", pktDone); end
        checks++;
        if (dropCount !== 8'd0) begin errors++; $display("[TB] FAIL rst_drop: got %0d required 0", dropCount); end
        checks++;
        if (transportBusy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %0b required 0", transportBusy); end
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (txValid !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_valid: got %0b required 0", txValid); end
    endtask

    task automatic test_control();
        logic [7:0] golden [6];
        bit ok;
        golden = '{8'hA5, 8'h40, 8'h01, 8'h00, 8'h01, 8'h42};
        obs_log.delete();
        txReady = 1'b1;
        send_word(2'b01, 16'h0001);
        checks++;
        if (transportBusy !== 1'b1) begin errors++; $display("[TB] FAIL ctrl_busy: got %0b required 1", transportBusy); end
        drain(100, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL ctrl_drain: got timeout required idle"); end
        checks++;
        if (obs_log.size() != 6) begin
            errors++; $display("[TB] FAIL ctrl_len: got %0d bytes required 6", obs_log.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (obs_log[i] !== golden[i]) begin
                    errors++; $display("[TB] FAIL ctrl_byte%0d: got %02h required %02h", i, obs_log[i], golden[i]);
                end
            end
        end
    endtask

    task automatic test_audio();
        logic [7:0] golden [12];
        bit ok;
        golden = '{8'hA5, 8'h81, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hBD};
        obs_log.delete();
        txReady = 1'b1;
        send_word(2'b10, 16'h1234);
        send_word(2'b10, 16'h5678);
        send_word(2'b10, 16'h9ABC);
        send_word(2'b10, 16'hDEF0);
        drain(100, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL audio_drain: got timeout required idle"); end
        checks++;
        if (obs_log.size() != 12) begin
            errors++; $display("[TB] FAIL audio_len: got %0d bytes required 12", obs_log.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (obs_log[i] !== golden[i]) begin
                    errors++; $display("[TB] FAIL audio_byte%0d: got %02h required %02h", i, obs_log[i], golden[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit seen;
        logic [7:0] held;
        obs_log.delete();
        txReady = 1'b1;
        for (int i = 0; i < AUDIO_WORDS; i++) send_word(2'b10, 16'($urandom));
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            if (in_flight && exp_idx >= 5) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL stall_reach: got timeout required payload"); end
        txReady = 1'b0;
        held = txByte;
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (txValid !== 1'b1 || txByte !== held) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: valid=%0b byte=%02h required valid=1 byte=%02h", n, txValid, txByte, held);
            end
        end
        drain(100, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL stall_drain: got timeout required idle"); end
        checks++;
        if (obs_log.size() != 12) begin errors++; $display("[TB] FAIL stall_len: got %0d required 12", obs_log.size()); end
    endtask

    task automatic test_full_drop();
        bit ok;
        int pkts;
        obs_log.delete();
        pkts = pkt_count;
        txReady = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) send_word(2'b10, 16'($urandom));
        checks++;
        if (transportBusy !== 1'b1) begin errors++; $display("[TB] FAIL full_busy: got %0b required 1", transportBusy); end
        for (int i = 0; i < 3; i++) send_word(2'b10, 16'($urandom));
        send_word(2'b11, 16'hFFFF);
        checks++;
        if (dropCount !== 8'd3) begin errors++; $display("[TB] FAIL full_drop: got %0d required 3", dropCount); end
        checks++;
        if (obs_log.size() != 0) begin errors++; $display("[TB] FAIL full_stalled: got %0d bytes required 0", obs_log.size()); end
        drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL full_drain: got timeout required idle"); end
        checks++;
        if (pkt_count - pkts != 2) begin errors++; $display("[TB] FAIL full_pkts: got %0d required 2", pkt_count - pkts); end
    endtask

    task automatic test_ctrl_during_audio();
        bit ok;
        bit seen;
        int n_hdr;
        int n_obs;
        obs_log.delete();
        txReady = 1'b1;
        for (int i = 0; i < AUDIO_WORDS; i++) send_word(2'b10, 16'($urandom));
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            if (in_flight && !exp_is_ctrl && exp_idx >= 2) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL cda_reach: got timeout required audio packet"); end
        send_word(2'b01, 16'h0005);
        drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL cda_drain: got timeout required idle"); end
        n_hdr = hdr_log.size();
        n_obs = obs_log.size();
        checks++;
        if (n_obs != 18 || n_hdr < 2) begin
            errors++; $display("[TB] FAIL cda_len: got %0d bytes required 18", n_obs);
        end else begin
            checks++;
            if (hdr_log[n_hdr-2][7:6] !== 2'b10) begin
                errors++; $display("[TB] FAIL cda_first_type: got %02b required 10", hdr_log[n_hdr-2][7:6]);
            end
            checks++;
            if (hdr_log[n_hdr-1][7:6] !== 2'b01) begin
                errors++; $display("[TB] FAIL cda_second_type: got %02b required 01", hdr_log[n_hdr-1][7:6]);
            end
            checks++;
            if (obs_log[15] !== 8'h00 || obs_log[16] !== 8'h05) begin
                errors++; $display("[TB] FAIL cda_payload: got %02h%02h required 0005", obs_log[15], obs_log[16]);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int r;
        for (int n = 0; n < 500; n++) begin
            txReady = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 4)       cmd = 2'b10;
            else if (r < 5)  cmd = 2'b01;
            else if (r < 6)  cmd = 2'b11;
            else             cmd = 2'b00;
            dataIn = 16'($urandom);
            tick();
        end
        cmd = 2'b00;
        drain(500, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL rand_drain: got timeout required idle"); end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        bit seen;
        obs_log.delete();
        txReady = 1'b1;
        for (int i = 0; i < AUDIO_WORDS; i++) send_word(2'b10, 16'($urandom));
        seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            if (in_flight && exp_idx >= 4) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin errors++; $display("[TB] FAIL rmp_reach: got timeout required payload"); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (txValid !== 1'b0) begin errors++; $display("[TB] FAIL rmp_valid: got %0b required 0", txValid); end
        checks++;
        if (txByte !== 8'h00) begin errors++; $display("[TB] FAIL rmp_byte: got %02h required 00", txByte); end
        checks++;
        if (dropCount !== 8'd0) begin errors++; $display("[TB] FAIL rmp_drop: got %0d required 0", dropCount); end
        checks++;
        if (transportBusy !== 1'b0) begin errors++; $display("[TB] FAIL rmp_busy: got %0b required 0", transportBusy); end
        tick();
        tick();
        reset = 1'b1;
        obs_log.delete();
        for (int n = 0; n < 10; n++) begin
            tick();
            checks++;
            if (txValid !== 1'b0) begin errors++; $display("[TB] FAIL rmp_quiet%0d: got %0b required 0", n, txValid); end
        end
        send_word(2'b01, 16'hBEEF);
        drain(100, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL rmp_drain: got timeout required idle"); end
        checks++;
        if (obs_log.size() != 6) begin
            errors++; $display("[TB] FAIL rmp_len: got %0d required 6", obs_log.size());
        end else begin
            checks++;
            if (obs_log[1] !== 8'h40) begin errors++; $display("[TB] FAIL rmp_seq: got %02h required 40", obs_log[1]); end
            checks++;
            if (obs_log[5] !== 8'hEE) begin errors++; $display("[TB] FAIL rmp_csum: got %02h required EE", obs_log[5]); end
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_control();
        test_audio();
        test_stall();
        test_full_drop();
        test_ctrl_during_audio();
        test_random();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
